// File: rtl/gpio_ctrl_pkg.sv
// Shared constants, register selector type and small helpers for the GPIO controller.
package gpio_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   // Byte offsets of the mapped registers
   localparam logic [ADDR_W-1:0] OFF_IN      = 5'h00;
   localparam logic [ADDR_W-1:0] OFF_OUT     = 5'h04;
   localparam logic [ADDR_W-1:0] OFF_DIR     = 5'h08;
   localparam logic [ADDR_W-1:0] OFF_RISE_EN = 5'h0C;
   localparam logic [ADDR_W-1:0] OFF_FALL_EN = 5'h10;
   localparam logic [ADDR_W-1:0] OFF_PENDING = 5'h14;

   typedef enum logic [2:0] {
      SEL_IN,
      SEL_OUT,
      SEL_DIR,
      SEL_RISE_EN,
      SEL_FALL_EN,
      SEL_PENDING,
      SEL_NONE
   } reg_sel_e;

   // Map a byte address to a register; the two low address bits are ignored
   // because all accesses are word aligned.
   function automatic reg_sel_e reg_decode(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] word;
      reg_sel_e          sel;
      word = {addr[ADDR_W-1:2], 2'b00};
      case (word)
         OFF_IN:      sel = SEL_IN;
         OFF_OUT:     sel = SEL_OUT;
         OFF_DIR:     sel = SEL_DIR;
         OFF_RISE_EN: sel = SEL_RISE_EN;
         OFF_FALL_EN: sel = SEL_FALL_EN;
         OFF_PENDING: sel = SEL_PENDING;
         default:     sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   // Width of the debounce stable counter; never below one bit so the
   // declaration stays legal when the filter is bypassed.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pin of the input path: synchroniser chain, debounce filter and
// single-cycle rise/fall strobes that coincide with the filtered update.
module gpio_debounce
   import gpio_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync;
   logic                   synced;
   logic                   level_next;

   assign synced = sync[SYNC_STAGES-1];

   // Shift the asynchronous pad level through the synchroniser chain.
   // NOTE: state is always updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pad};
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass

      // Filter disabled: the filtered value follows the synchroniser output.
      always_comb begin
         level_next = synced;
      end

   end else begin : g_filter

      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;

      // Count consecutive cycles in which the synchronised value disagrees
      // with the filtered value; any agreement or an accepted change restarts it.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt <= '0;
         end else if (synced == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end

      // Accept the new level on the cycle the disagreement has lasted long enough.
      // NOTE: the default assignment first keeps always_comb free of latches.
      always_comb begin
         level_next = level;
         if ((synced != level) && (cnt == CNT_LAST)) begin
            level_next = synced;
         end
      end

   end

   // Filtered-value flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= 1'b0;
      end else begin
         level <= level_next;
      end
   end

   // Strobes are derived from the next value so they line up with the flop update.
   assign rise = ~rst & ~level &  level_next;
   assign fall = ~rst &  level & ~level_next;

endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: APB3 register file, per-pin direction and
// output, debounced inputs and W1C edge-interrupt pending register.
module gpio_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              io_sys_clock,
   input  logic              io_sys_reset,
   input  logic [ADDR_W-1:0] io_apb_PADDR,
   input  logic              io_apb_PSEL,
   input  logic              io_apb_PENABLE,
   input  logic              io_apb_PWRITE,
   input  logic [DATA_W-1:0] io_apb_PWDATA,
   output logic [DATA_W-1:0] io_apb_PRDATA,
   output logic              io_apb_PREADY,
   output logic              io_apb_PSLVERR,
   input  logic [WIDTH-1:0]  io_pins_read,
   output logic [WIDTH-1:0]  io_pins_write,
   output logic [WIDTH-1:0]  io_pins_writeEnable,
   output logic              io_irq
);

   logic             access;
   logic             wr_access;
   logic             rd_access;
   reg_sel_e         sel;
   logic [WIDTH-1:0] wdata;

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] rise_en_q;
   logic [WIDTH-1:0] fall_en_q;
   logic [WIDTH-1:0] pending_q;
   logic             irq_q;

   logic [WIDTH-1:0] in_level;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] pend_set;
   logic [WIDTH-1:0] pend_clr;

   logic             unused_wdata;

   // ---------------------------------------------------------------- decode
   assign access    = io_apb_PSEL & io_apb_PENABLE;
   assign wr_access = access &  io_apb_PWRITE;
   assign rd_access = access & ~io_apb_PWRITE;
   assign sel       = reg_decode(io_apb_PADDR);
   assign wdata     = io_apb_PWDATA[WIDTH-1:0];

   // Bits at and above WIDTH are ignored on write.
   assign unused_wdata = ^io_apb_PWDATA;

   // ------------------------------------------------------------ input path
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      gpio_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (io_sys_clock),
         .rst   (io_sys_reset),
         .pad   (io_pins_read[i]),
         .level (in_level[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );
   end

   // ------------------------------------------------------------ registers

   // Read/write control registers, updated at the end of a write access.
   always_ff @(posedge io_sys_clock) begin
      if (io_sys_reset) begin
         out_q     <= '0;
         dir_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
      end else if (wr_access) begin
         case (sel)
            SEL_OUT:     out_q     <= wdata;
            SEL_DIR:     dir_q     <= wdata;
            SEL_RISE_EN: rise_en_q <= wdata;
            SEL_FALL_EN: fall_en_q <= wdata;
            default:     ;
         endcase
      end
   end

   // Enabled filtered edges set pending bits; a W1C only clears bits that are
   // not being set in the same cycle.
   assign pend_set = (rise & rise_en_q) | (fall & fall_en_q);
   assign pend_clr = (wr_access && (sel == SEL_PENDING)) ? wdata : '0;

   // Pending register: set has priority over clear.
   always_ff @(posedge io_sys_clock) begin
      if (io_sys_reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= (pending_q & ~pend_clr) | pend_set;
      end
   end

   // Registered interrupt line, one cycle behind the pending register.
   always_ff @(posedge io_sys_clock) begin
      if (io_sys_reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |pending_q;
      end
   end

   // ------------------------------------------------------------- read path

   // Combinational read data and error response from the current state.
   always_comb begin
      io_apb_PRDATA  = '0;
      io_apb_PSLVERR = 1'b0;
      if (access) begin
         if (sel == SEL_NONE) begin
            io_apb_PSLVERR = 1'b1;
         end else if (rd_access) begin
            case (sel)
               SEL_IN:      io_apb_PRDATA = DATA_W'(in_level);
               SEL_OUT:     io_apb_PRDATA = DATA_W'(out_q);
               SEL_DIR:     io_apb_PRDATA = DATA_W'(dir_q);
               SEL_RISE_EN: io_apb_PRDATA = DATA_W'(rise_en_q);
               SEL_FALL_EN: io_apb_PRDATA = DATA_W'(fall_en_q);
               SEL_PENDING: io_apb_PRDATA = DATA_W'(pending_q);
               default:     io_apb_PRDATA = '0;
            endcase
         end
      end
   end

   // --------------------------------------------------------------- outputs
   assign io_apb_PREADY       = 1'b1;
   assign io_pins_write       = out_q;
   assign io_pins_writeEnable = dir_q;
   assign io_irq              = irq_q;

endmodule
